aes_key_schedule: RTL and testbench



---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_sbox.sv | 34 +++
 rtl/aes_sub_word.sv | 16 +
 rtl/aes_key_schedule.sv | 112 +++++++++++
 tb/tb_aes_key_schedule.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers used by the cipher datapath.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    localparam int unsigned AES_ROUNDS = 10;
    localparam logic [7:0]  RCON_INIT  = 8'h01;
    localparam logic [7:0]  AES_POLY   = 8'h1b;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = gf_mul(x, x);
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            res = gf_mul(res, sq);
            sq  = gf_mul(sq, sq);
        end
        return res;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv    = gf_inv(byte_i);
        byte_o = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;
    end

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_i (word_i[8*g +: 8]),
            .byte_o (word_o[8*g +: 8])
        );
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: streams round keys 0..10 over a valid/ready handshake,
// holding only the current round key and deriving the next one combinationally from it.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         done
);

    if (NUM_ROUNDS != AES_ROUNDS) begin : g_bad_rounds
        $error("aes_key_schedule supports only NUM_ROUNDS = 10 (AES-128)");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    ks_state_t  state_q, state_d;
    state_t     rk_q, rk_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;
    logic       done_q, done_d;

    word_t w0, w1, w2, w3;
    word_t rot_w3, sub_w3, t_word;
    word_t n0, n1, n2, n3;

    assign w0 = rk_q[127:96];
    assign w1 = rk_q[95:64];
    assign w2 = rk_q[63:32];
    assign w3 = rk_q[31:0];

    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_sub_word u_sub_word (
        .word_i (rot_w3),
        .word_o (sub_w3)
    );

    assign t_word = sub_w3 ^ {rcon_q, 24'h0};
    assign n0     = w0 ^ t_word;
    assign n1     = w1 ^ n0;
    assign n2     = w2 ^ n1;
    assign n3     = w3 ^ n2;

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rk_d    = key_in;
                    round_d = 4'd0;
                    rcon_d  = RCON_INIT;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        rk_d    = {n0, n1, n2, n3};
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rk_q    <= '0;
            round_q <= '0;
            rcon_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q == EMIT);
    assign rk_out   = rk_q;
    assign rk_round = round_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 vectors plus random keys checked
// against a word-array key-expansion model built on a generator-derived S-box table.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         done;

    always #5 clk = ~clk;

    aes_key_schedule #(.NUM_ROUNDS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .done     (done)
    );

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK10_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_tb  [256];
    logic [127:0] exp_keys [11];
    logic [127:0] got_keys [11];

    typedef struct {
        logic [127:0] key;
        int           round;
        logic [127:0] rk;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    // S-box from walking the multiplicative group: p steps by 3, q by 1/3 = p^-1.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            sbox_tb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox_tb[0] = 8'h63;
    endtask

    task automatic model_keys(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc [10];
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tb[t[31:24]], sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]]};
                t = t ^ {rc[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_expand(input logic [127:0] key, input bit bp, input int busy_round,
                             input bit finish_start);
        int r;
        int stall;
        bit fin;
        model_keys(key);
        start  = 1'b1;
        key_in = key;
        @(negedge clk);
        start  = 1'b0;
        key_in = rand128();
        r      = 0;
        stall  = 0;
        fin    = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            check($sformatf("flags {valid,busy,done} at r%0d", r),
                  {rk_valid, busy, done}, 128'b110);
            check($sformatf("rk_round at r%0d", r), rk_round, 128'(r));
            check($sformatf("rk_out at r%0d", r), rk_out, exp_keys[r]);
            got_keys[r] = rk_out;
            if (bp) begin
                if (stall > 0) begin
                    rk_ready = 1'b0;
                    stall--;
                end else if ($urandom_range(0, 2) == 0) begin
                    rk_ready = 1'b0;
                    stall    = 2;
                end else begin
                    rk_ready = 1'b1;
                end
            end else begin
                rk_ready = 1'b1;
            end
            start  = (r == busy_round);
            key_in = (r == busy_round) ? '0 : rand128();
            if (rk_ready) begin
                if (r == 10) fin = 1'b1;
                else r++;
            end
        end
        start = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL stream timeout: reached round %0d, required 10", r);
        end
        @(negedge clk);
        check("flags after last handshake", {rk_valid, busy, done}, 128'b001);
        if (finish_start) begin
            start  = 1'b1;
            key_in = rand128();
        end
        @(negedge clk);
        start = 1'b0;
        check("flags back in idle", {rk_valid, busy, done}, 128'b000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;
        build_sbox();

        vecs[0] = '{key: 128'h0, round: 0, rk: 128'h0};
        vecs[1] = '{key: 128'h0, round: 1, rk: 128'h62636363626363636263636362636363};
        vecs[2] = '{key: KEY_A1, round: 0, rk: KEY_A1};
        vecs[3] = '{key: KEY_A1, round: 1, rk: 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[4] = '{key: KEY_A1, round: 2, rk: 128'hf2c295f27a96b9435935807a7359f67f};
        vecs[5] = '{key: KEY_A1, round: 9, rk: 128'hac7766f319fadc2128d12941575c006e};
        vecs[6] = '{key: KEY_A1, round: 10, rk: RK10_A1};

        repeat (2) @(negedge clk);
        check("reset rk_out", rk_out, 128'h0);
        check("reset rk_round", rk_round, 128'h0);
        check("reset flags", {rk_valid, busy, done}, 128'b000);
        rst = 1'b0;

        // Abort mid-expansion with reset.
        @(negedge clk);
        start    = 1'b1;
        key_in   = KEY_A1;
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && rk_round != 4'd5; i++) @(negedge clk);
        check("reached round 5 before reset", rk_round, 128'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-run reset rk_out", rk_out, 128'h0);
        check("mid-run reset rk_round", rk_round, 128'h0);
        check("mid-run reset flags", {rk_valid, busy, done}, 128'b000);

        // Reset wins over a start in idle.
        rst    = 1'b1;
        start  = 1'b1;
        key_in = KEY_A1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("start under reset ignored", {rk_valid, busy, done, rk_out}, 131'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("no done after reset c%0d", i), {rk_valid, busy, done}, 128'b000);
        end

        // Known-answer vectors; consecutive expansions run back-to-back.
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || vecs[i].key != vecs[i-1].key) do_expand(vecs[i].key, 1'b0, -1, 1'b0);
            check($sformatf("vector %0d round %0d", i, vecs[i].round),
                  got_keys[vecs[i].round], vecs[i].rk);
        end

        do_expand(KEY_A1, 1'b1, -1, 1'b1);
        check("backpressure round 10", got_keys[10], RK10_A1);

        do_expand(KEY_A1, 1'b0, 4, 1'b0);
        check("start while busy round 10", got_keys[10], RK10_A1);

        for (int i = 0; i < 6; i++) begin
            do_expand(rand128(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                      1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
